// File: rtl/morse_pkg.sv
// Shared Morse timing default, state encodings and letter code tables
// for the tt_um_morse_codec transmitter and receiver.
package morse_pkg;

  localparam int UNIT_DEF  = 8;
  localparam int N_LETTERS = 26;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_MARK,
    TX_SPACE,
    TX_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_MARK,
    RX_SPACE
  } rx_state_t;

  // pat is left-aligned: first symbol in bit 3, 1 = dash, unused low bits are 0
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } morse_code_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } morse_match_t;

  function automatic morse_code_t letter_code(input logic [4:0] idx);
    morse_code_t c;
    case (idx)
      5'd0:    c = '{3'd2, 4'b0100};  // A .-
      5'd1:    c = '{3'd4, 4'b1000};  // B -...
      5'd2:    c = '{3'd4, 4'b1010};  // C -.-.
      5'd3:    c = '{3'd3, 4'b1000};  // D -..
      5'd4:    c = '{3'd1, 4'b0000};  // E .
      5'd5:    c = '{3'd4, 4'b0010};  // F ..-.
      5'd6:    c = '{3'd3, 4'b1100};  // G --.
      5'd7:    c = '{3'd4, 4'b0000};  // H ....
      5'd8:    c = '{3'd2, 4'b0000};  // I ..
      5'd9:    c = '{3'd4, 4'b0111};  // J .---
      5'd10:   c = '{3'd3, 4'b1010};  // K -.-
      5'd11:   c = '{3'd4, 4'b0100};  // L .-..
      5'd12:   c = '{3'd2, 4'b1100};  // M --
      5'd13:   c = '{3'd2, 4'b1000};  // N -.
      5'd14:   c = '{3'd3, 4'b1110};  // O ---
      5'd15:   c = '{3'd4, 4'b0110};  // P .--.
      5'd16:   c = '{3'd4, 4'b1101};  // Q --.-
      5'd17:   c = '{3'd3, 4'b0100};  // R .-.
      5'd18:   c = '{3'd3, 4'b0000};  // S ...
      5'd19:   c = '{3'd1, 4'b1000};  // T -
      5'd20:   c = '{3'd3, 4'b0010};  // U ..-
      5'd21:   c = '{3'd4, 4'b0001};  // V ...-
      5'd22:   c = '{3'd3, 4'b0110};  // W .--
      5'd23:   c = '{3'd4, 4'b1001};  // X -..-
      5'd24:   c = '{3'd4, 4'b1011};  // Y -.--
      5'd25:   c = '{3'd4, 4'b1100};  // Z --..
      default: c = '{3'd0, 4'b0000};
    endcase
    return c;
  endfunction

  function automatic morse_match_t code_lookup(input logic [3:0] pat, input logic [2:0] len);
    morse_match_t m;
    morse_code_t  c;
    m = '{1'b0, 5'd0};
    for (int i = 0; i < N_LETTERS; i++) begin
      c = letter_code(5'(i));
      if ((c.len == len) && (c.pat == pat)) begin
        m = '{1'b1, 5'(i)};
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/morse_rx_fsm.sv
// Morse receiver: synchronizes and times the key line, decodes letters.
//   state    | meaning
//   RX_IDLE  | line low, no symbols collected
//   RX_MARK  | key high, mark length being counted
//   RX_SPACE | key low after a symbol, waiting for letter gap
module morse_rx_fsm
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = UNIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key,
  output logic       o_valid,
  output logic       o_error,
  output logic [4:0] o_letter
);

  localparam int CW = $clog2(3 * UNIT_CYCLES) + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'(3 * UNIT_CYCLES - 1);

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_hi_cnt;
  logic [CW-1:0] r_lo_cnt;
  logic [3:0]    r_pat;
  logic [2:0]    r_sym_cnt;
  logic          r_ovf;
  logic          r_valid;
  logic          r_error;
  logic [4:0]    r_letter;
  logic          w_key;
  logic          w_dash;
  logic          w_decode;
  logic [3:0]    w_aligned;
  morse_match_t  w_match;

  assign w_key = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_key) w_next = RX_MARK;
      RX_MARK:  if (!w_key) w_next = RX_SPACE;
      RX_SPACE: begin
        if (w_key) w_next = RX_MARK;
        else if (r_lo_cnt == GAP_LAST) w_next = RX_IDLE;
      end
      default:  w_next = RX_IDLE;
    endcase
  end

  // Pattern is collected right-aligned; the table wants it left-aligned
  always_comb begin
    w_dash   = (r_hi_cnt >= DASH_MIN);
    w_decode = (r_state == RX_SPACE) && !w_key && (r_lo_cnt == GAP_LAST);
    case (r_sym_cnt)
      3'd1:    w_aligned = {r_pat[0], 3'b000};
      3'd2:    w_aligned = {r_pat[1:0], 2'b00};
      3'd3:    w_aligned = {r_pat[2:0], 1'b0};
      default: w_aligned = r_pat;
    endcase
    w_match  = code_lookup(w_aligned, r_sym_cnt);
    o_valid  = r_valid;
    o_error  = r_error;
    o_letter = r_letter;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_hi_cnt  <= '0;
      r_lo_cnt  <= '0;
      r_pat     <= '0;
      r_sym_cnt <= '0;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_letter  <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_key};
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_key) r_hi_cnt <= ONE;
        end
        RX_MARK: begin
          if (w_key) begin
            if (r_hi_cnt != CNT_MAX) r_hi_cnt <= r_hi_cnt + ONE;
          end else begin
            r_lo_cnt <= ONE;
            if (r_sym_cnt == 3'd4) begin
              r_ovf <= 1'b1;
            end else begin
              r_pat     <= {r_pat[2:0], w_dash};
              r_sym_cnt <= r_sym_cnt + 3'd1;
            end
          end
        end
        RX_SPACE: begin
          if (w_key) begin
            r_hi_cnt <= ONE;
          end else if (w_decode) begin
            if (w_match.valid && !r_ovf) begin
              r_letter <= w_match.idx;
              r_valid  <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
            r_pat     <= '0;
            r_sym_cnt <= '0;
            r_ovf     <= 1'b0;
          end else begin
            r_lo_cnt <= r_lo_cnt + ONE;
          end
        end
        default: r_hi_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/morse_tx_fsm.sv
// Morse transmitter: keys one latched letter as timed dots and dashes.
//   state    | meaning
//   TX_IDLE  | waiting for a start edge with a valid index
//   TX_MARK  | key high for one symbol (1 or 3 units)
//   TX_SPACE | key low for one unit between symbols
//   TX_GAP   | key low for three units after the last symbol
module morse_tx_fsm
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = UNIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_idx,
  input  logic       i_start,
  output logic       o_key,
  output logic       o_busy
);

  localparam int CW = $clog2(3 * UNIT_CYCLES) + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DOT_LD  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LD = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(3 * UNIT_CYCLES - 1);

  tx_state_t     r_state;
  tx_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_pat;
  logic [2:0]    r_left;
  logic          r_start_d;
  logic          w_tc;
  logic          w_go;
  logic          w_more;
  morse_code_t   w_code;

  assign w_code = letter_code(i_idx);
  assign w_tc   = (r_cnt == '0);
  assign w_go   = (r_state == TX_IDLE) && i_start && !r_start_d && (i_idx <= 5'd25);
  assign w_more = (r_left > 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE:  if (w_go) w_next = TX_MARK;
      TX_MARK:  if (w_tc) w_next = w_more ? TX_SPACE : TX_GAP;
      TX_SPACE: if (w_tc) w_next = TX_MARK;
      TX_GAP:   if (w_tc) w_next = TX_IDLE;
      default:  w_next = TX_IDLE;
    endcase
  end

  always_comb begin
    o_key  = (r_state == TX_MARK);
    o_busy = (r_state != TX_IDLE);
  end

  // r_pat[3] is always the symbol currently being (or about to be) keyed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pat     <= '0;
      r_left    <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= i_start;
      case (r_state)
        TX_IDLE: begin
          if (w_go) begin
            r_pat  <= w_code.pat;
            r_left <= w_code.len;
            r_cnt  <= w_code.pat[3] ? DASH_LD : DOT_LD;
          end
        end
        TX_MARK: begin
          if (!w_tc) begin
            r_cnt <= r_cnt - ONE;
          end else if (w_more) begin
            r_pat  <= {r_pat[2:0], 1'b0};
            r_left <= r_left - 3'd1;
            r_cnt  <= DOT_LD;
          end else begin
            r_cnt <= GAP_LD;
          end
        end
        TX_SPACE: begin
          if (!w_tc) begin
            r_cnt <= r_cnt - ONE;
          end else begin
            r_cnt <= r_pat[3] ? DASH_LD : DOT_LD;
          end
        end
        TX_GAP: begin
          if (!w_tc) r_cnt <= r_cnt - ONE;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_morse_codec.sv
// Tiny Tapeout tile wrapper: maps pins onto the Morse transmitter and receiver.
module tt_um_morse_codec
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = UNIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       w_tx_key;
  logic       w_tx_busy;
  logic       w_rx_valid;
  logic       w_rx_error;
  logic [4:0] w_rx_letter;
  logic       w_unused;

  morse_tx_fsm #(.UNIT_CYCLES(UNIT_CYCLES)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_idx  (ui_in[4:0]),
    .i_start(ui_in[5]),
    .o_key  (w_tx_key),
    .o_busy (w_tx_busy)
  );

  morse_rx_fsm #(.UNIT_CYCLES(UNIT_CYCLES)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key   (ui_in[6]),
    .o_valid (w_rx_valid),
    .o_error (w_rx_error),
    .o_letter(w_rx_letter)
  );

  assign uo_out   = {w_rx_letter, w_rx_valid, w_tx_busy, w_tx_key};
  assign uio_out  = {7'b0000000, w_rx_error};
  assign uio_oe   = 8'h01;
  assign w_unused = &{1'b0, ena, ui_in[7], uio_in};

endmodule

// File: tb/tb_tt_um_morse_codec.sv
// Directed bench for tt_um_morse_codec: TX timing, RX decode/error, loopback.
module tb_tt_um_morse_codec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [4:0] idx = 5'd0;
  logic       start = 1'b0;
  logic       rxk_drv = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] ui_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  assign ui_in = {1'b0, (loop_en ? uo_out[0] : rxk_drv), start, idx};

  tt_um_morse_codec dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tot_valid = 0;
  int tot_err = 0;
  logic [4:0] last_letter = 5'd0;

  always @(negedge clk) begin
    if (uo_out[2]) begin
      tot_valid++;
      last_letter = uo_out[7:3];
    end
    if (uio_out[0]) tot_err++;
  end

  logic key_log[128];
  logic busy_log[128];
  int   runs[8];
  int   nruns;
  int   busy_len;
  int   key_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples tx_key/tx_busy each falling edge; releases start after the first sample
  task automatic capture(input int n, input int restart_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_log[i]  = uo_out[0];
      busy_log[i] = uo_out[1];
      if (i == 0) start = 1'b0;
      if (i == restart_at) begin
        start = 1'b1;
        idx   = 5'd4;
      end
      if (i == restart_at + 1) start = 1'b0;
    end
  endtask

  task automatic get_runs(input int n);
    busy_len = 0;
    key_cnt  = 0;
    nruns    = 0;
    for (int k = 0; k < 8; k++) runs[k] = 0;
    for (int i = 0; i < n; i++) begin
      if (key_log[i]) key_cnt++;
      if (busy_log[i]) begin
        busy_len++;
        if (i == 0 || key_log[i] != key_log[i-1] || !busy_log[i-1]) nruns++;
        if (nruns >= 1 && nruns <= 8) runs[nruns-1]++;
      end
    end
  endtask

  task automatic rx_drive(input logic lvl, input int n);
    rxk_drv = lvl;
    repeat (n) @(negedge clk);
  endtask

  int base_v;
  int base_e;
  int wcnt;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_uo_out", uo_out, 0);
    chk("rst_uio_out", uio_out, 0);
    chk("rst_uio_oe", uio_oe, 8'h01);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_uo_out", uo_out, 0);
    chk("post_rst_uio_out", uio_out, 0);
    chk("post_rst_uio_oe", uio_oe, 8'h01);

    // TX 'E': one dot, then a three-unit gap
    idx = 5'd4;
    start = 1'b1;
    capture(40, -1);
    get_runs(40);
    chk("txE_first_key", key_log[0], 1);
    chk("txE_first_busy", busy_log[0], 1);
    chk("txE_busy_len", busy_len, 32);
    chk("txE_nruns", nruns, 2);
    chk("txE_mark", runs[0], 8);

    // TX 'A' with a second start edge part-way through
    idx = 5'd0;
    start = 1'b1;
    capture(100, 10);
    get_runs(100);
    chk("txA_first_key", key_log[0], 1);
    chk("txA_busy_len", busy_len, 64);
    chk("txA_nruns", nruns, 4);
    chk("txA_run0", runs[0], 8);
    chk("txA_run1", runs[1], 8);
    chk("txA_run2", runs[2], 24);
    chk("txA_run3", runs[3], 24);

    // Out-of-range index never starts the transmitter
    idx = 5'd27;
    start = 1'b1;
    capture(20, -1);
    get_runs(20);
    chk("tx27_busy", busy_len, 0);
    chk("tx27_key", key_cnt, 0);

    // RX 'A'
    base_v = tot_valid;
    base_e = tot_err;
    rx_drive(1'b1, 8);
    rx_drive(1'b0, 8);
    rx_drive(1'b1, 24);
    rx_drive(1'b0, 40);
    chk("rxA_valid", tot_valid - base_v, 1);
    chk("rxA_err", tot_err - base_e, 0);
    chk("rxA_letter", uo_out[7:3], 0);

    // Key held far past counter range still classifies as dash -> 'T'
    base_v = tot_valid;
    base_e = tot_err;
    rx_drive(1'b1, 70);
    rx_drive(1'b0, 40);
    chk("rxHold_valid", tot_valid - base_v, 1);
    chk("rxHold_err", tot_err - base_e, 0);
    chk("rxHold_letter", uo_out[7:3], 19);

    // 23-cycle low is short of the letter gap: two dots form 'I'
    base_v = tot_valid;
    base_e = tot_err;
    rx_drive(1'b1, 8);
    rx_drive(1'b0, 23);
    rx_drive(1'b1, 8);
    rx_drive(1'b0, 40);
    chk("rxI_valid", tot_valid - base_v, 1);
    chk("rxI_err", tot_err - base_e, 0);
    chk("rxI_letter", uo_out[7:3], 8);

    // Five dots overflow: error pulse, letter keeps 'I'
    base_v = tot_valid;
    base_e = tot_err;
    for (int s = 0; s < 5; s++) begin
      rx_drive(1'b1, 8);
      rx_drive(1'b0, 8);
    end
    rx_drive(1'b0, 40);
    chk("rxOvf_err", tot_err - base_e, 1);
    chk("rxOvf_valid", tot_valid - base_v, 0);
    chk("rxOvf_letter", uo_out[7:3], 8);

    // Idle line produces nothing
    base_v = tot_valid;
    base_e = tot_err;
    rx_drive(1'b0, 60);
    chk("rxIdle_valid", tot_valid - base_v, 0);
    chk("rxIdle_err", tot_err - base_e, 0);

    // Loopback of every letter
    loop_en = 1'b1;
    for (int i = 0; i < 26; i++) begin
      base_v = tot_valid;
      base_e = tot_err;
      idx   = 5'(i);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wcnt  = 0;
      while (uo_out[1] && wcnt < 200) begin
        @(negedge clk);
        wcnt++;
      end
      chk($sformatf("lb%0d_busy_drop", i), uo_out[1], 0);
      repeat (40) @(negedge clk);
      chk($sformatf("lb%0d_valid", i), tot_valid - base_v, 1);
      chk($sformatf("lb%0d_err", i), tot_err - base_e, 0);
      chk($sformatf("lb%0d_letter", i), last_letter, i);
    end
    loop_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
